// File: rtl/key_receiver.sv
// Ignition-lock receiver: assembles an LSB-first serial key, compares it to the
// stored key, and enforces a timed lockout after repeated mismatches.
module key_receiver #(
  parameter int                      NBITS_STREAM   = 4,
  parameter logic [NBITS_STREAM-1:0] KEY_VALUE      = 'b1101,
  parameter int                      MAX_TRIES      = 3,
  parameter int                      TIMEOUT_CYCLES = 8,
  parameter int                      LOCKOUT_CYCLES = 16
) (
  input  logic                                 clk_2,
  input  logic                                 reset,
  input  logic                                 bit_valid,
  input  logic                                 din,
  input  logic                                 relock,
  output logic                                 unlocked,
  output logic                                 key_error,
  output logic                                 timeout,
  output logic                                 locked_out,
  output logic [$clog2(NBITS_STREAM+1)-1:0]    bit_count,
  output logic [$clog2(MAX_TRIES+1)-1:0]       fail_count,
  output logic [2:0]                           state_dbg
);

  localparam int BCW = $clog2(NBITS_STREAM + 1);
  localparam int FCW = $clog2(MAX_TRIES + 1);
  localparam int ICW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LCW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RECEIVE  = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_UNLOCKED = 3'd3;
  localparam logic [2:0] S_LOCKOUT  = 3'd4;

  logic [2:0]              r_state;
  logic [NBITS_STREAM-1:0] r_shreg;
  logic [BCW-1:0]          r_bit_count;
  logic [FCW-1:0]          r_fail_count;
  logic [ICW-1:0]          r_idle_cnt;
  logic [LCW-1:0]          r_lock_cnt;
  logic                    r_key_error;
  logic                    r_timeout;

  logic [NBITS_STREAM-1:0] w_shreg_shift;

  // First bit received ends up in bit 0 once the word is complete.
  assign w_shreg_shift = {din, r_shreg[NBITS_STREAM-1:1]};

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk_2) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_bit_count  <= '0;
      r_fail_count <= '0;
      r_idle_cnt   <= '0;
      r_lock_cnt   <= '0;
      r_key_error  <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_key_error <= 1'b0;
      r_timeout   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bit_valid) begin
            r_shreg     <= w_shreg_shift;
            r_bit_count <= BCW'(1);
            r_idle_cnt  <= '0;
            r_state     <= S_RECEIVE;
          end
        end
        S_RECEIVE: begin
          // An arriving bit beats an expiring idle counter.
          if (bit_valid) begin
            r_shreg     <= w_shreg_shift;
            r_bit_count <= r_bit_count + BCW'(1);
            r_idle_cnt  <= '0;
            if (r_bit_count == BCW'(NBITS_STREAM - 1)) r_state <= S_CHECK;
          end else if (r_idle_cnt == ICW'(TIMEOUT_CYCLES - 1)) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_bit_count <= '0;
            r_idle_cnt  <= '0;
            r_timeout   <= 1'b1;
          end else begin
            r_idle_cnt <= r_idle_cnt + ICW'(1);
          end
        end
        S_CHECK: begin
          r_bit_count <= '0;
          r_shreg     <= '0;
          if (r_shreg == KEY_VALUE) begin
            r_state      <= S_UNLOCKED;
            r_fail_count <= '0;
          end else begin
            r_key_error  <= 1'b1;
            r_fail_count <= r_fail_count + FCW'(1);
            if (r_fail_count == FCW'(MAX_TRIES - 1)) begin
              r_state    <= S_LOCKOUT;
              r_lock_cnt <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_UNLOCKED: begin
          if (relock) r_state <= S_IDLE;
        end
        S_LOCKOUT: begin
          if (r_lock_cnt == LCW'(LOCKOUT_CYCLES - 1)) begin
            r_state      <= S_IDLE;
            r_fail_count <= '0;
            r_lock_cnt   <= '0;
          end else begin
            r_lock_cnt <= r_lock_cnt + LCW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign unlocked   = (r_state == S_UNLOCKED);
  assign locked_out = (r_state == S_LOCKOUT);
  assign state_dbg  = r_state;
  assign key_error  = r_key_error;
  assign timeout    = r_timeout;
  assign bit_count  = r_bit_count;
  assign fail_count = r_fail_count;

endmodule

// File: tb/tb_key_receiver.sv
// Scoreboard bench for key_receiver: attempt-level model pushes expected events,
// a negedge monitor pops them as the DUT reports unlock/error/timeout/lockout.
module tb_key_receiver;

  localparam int         N    = 4;
  localparam int         MAXT = 3;
  localparam int         TO   = 8;
  localparam int         LO   = 16;
  localparam logic [3:0] KEY  = 4'b1101;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic       bit_valid = 1'b0;
  logic       din = 1'b0;
  logic       relock = 1'b0;
  logic       unlocked, key_error, timeout, locked_out;
  logic [2:0] bit_count;
  logic [1:0] fail_count;
  logic [2:0] state_dbg;

  key_receiver #(
    .NBITS_STREAM(N), .KEY_VALUE(KEY), .MAX_TRIES(MAXT),
    .TIMEOUT_CYCLES(TO), .LOCKOUT_CYCLES(LO)
  ) dut (
    .clk_2(clk_2), .reset(reset), .bit_valid(bit_valid), .din(din), .relock(relock),
    .unlocked(unlocked), .key_error(key_error), .timeout(timeout),
    .locked_out(locked_out), .bit_count(bit_count), .fail_count(fail_count),
    .state_dbg(state_dbg)
  );

  always #5 clk_2 = ~clk_2;

  typedef enum int {EV_UNLOCK, EV_KEYERR, EV_TIMEOUT, EV_LOCKOUT} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       fail;
    int       state;
  } ev_t;
  typedef enum int {M_IDLE, M_UNLOCKED, M_LOCKED} mstate_e;

  ev_t     exp_q[$];
  int      n_cmp = 0;
  int      n_mis = 0;
  mstate_e m_state = M_IDLE;
  int      m_fail = 0;

  logic prev_lo = 1'b0, prev_ul = 1'b0, prev_ke = 1'b0, prev_to = 1'b0;
  int   lo_len = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic push(input ev_kind_e k, input int f, input int s);
    ev_t e;
    e.kind = k; e.fail = f; e.state = s;
    exp_q.push_back(e);
  endtask

  task automatic pop_expect(input ev_kind_e k, output ev_t e, output bit ok);
    check($sformatf("event_expected_kind%0d", int'(k)), int'(exp_q.size() != 0), 1);
    ok = (exp_q.size() != 0);
    if (ok) begin
      e = exp_q.pop_front();
      check("event_kind", int'(k), int'(e.kind));
    end
  endtask

  // Monitor: reacts only to what the DUT presents.
  initial begin : monitor
    ev_t e;
    bit  ok;
    forever begin
      @(negedge clk_2);
      if (!reset) begin
        prev_lo = 1'b0; prev_ul = 1'b0; prev_ke = 1'b0; prev_to = 1'b0; lo_len = 0;
      end else begin
        if (key_error) begin
          check("key_error_width", int'(prev_ke), 0);
          pop_expect(EV_KEYERR, e, ok);
          if (ok) begin
            check("keyerr_fail_count", int'(fail_count), e.fail);
            check("keyerr_state", int'(state_dbg), e.state);
            check("keyerr_unlocked", int'(unlocked), 0);
          end
        end
        if (timeout) begin
          check("timeout_width", int'(prev_to), 0);
          pop_expect(EV_TIMEOUT, e, ok);
          if (ok) begin
            check("timeout_bit_count", int'(bit_count), 0);
            check("timeout_fail_count", int'(fail_count), e.fail);
            check("timeout_state", int'(state_dbg), 0);
          end
        end
        if (unlocked && !prev_ul) begin
          pop_expect(EV_UNLOCK, e, ok);
          if (ok) begin
            check("unlock_state", int'(state_dbg), 3);
            check("unlock_fail_count", int'(fail_count), 0);
            check("unlock_bit_count", int'(bit_count), 0);
          end
        end
        if (locked_out) lo_len++;
        if (prev_lo && !locked_out) begin
          pop_expect(EV_LOCKOUT, e, ok);
          if (ok) begin
            check("lockout_length", lo_len, LO);
            check("lockout_exit_state", int'(state_dbg), 0);
            check("lockout_exit_fail_count", int'(fail_count), 0);
          end
          lo_len = 0;
        end
        prev_lo = locked_out; prev_ul = unlocked; prev_ke = key_error; prev_to = timeout;
      end
    end
  end

  // Model one complete attempt from the key rules, then drive its bits.
  task automatic send_attempt(input logic [3:0] w, input int gap);
    bit was_idle;
    was_idle = (m_state == M_IDLE);
    if (was_idle) begin
      if (w == KEY) begin
        push(EV_UNLOCK, 0, 3);
        m_state = M_UNLOCKED;
        m_fail  = 0;
      end else begin
        m_fail++;
        push(EV_KEYERR, m_fail, (m_fail == MAXT) ? 4 : 0);
        if (m_fail == MAXT) begin
          push(EV_LOCKOUT, 0, 0);
          m_state = M_LOCKED;
          m_fail  = 0;
        end
      end
    end
    // NOTE: stimulus is driven with blocking assignments one time unit after the
    // edge, so the DUT always samples settled inputs.
    for (int i = 0; i < N; i++) begin
      bit_valid = 1'b1;
      din       = w[i];
      tick();
      if (i < N - 1) begin
        bit_valid = 1'b0;
        repeat (gap) tick();
      end
    end
    bit_valid = 1'b0;
    if (was_idle) begin
      check("check_cycle_state", int'(state_dbg), 2);
      check("check_cycle_bit_count", int'(bit_count), N);
    end
    repeat (3) tick();
  endtask

  task automatic partial(input logic [3:0] w, input int nb);
    push(EV_TIMEOUT, m_fail, 0);
    for (int i = 0; i < nb; i++) begin
      bit_valid = 1'b1;
      din       = w[i];
      tick();
    end
    bit_valid = 1'b0;
    check("partial_bit_count", int'(bit_count), nb);
    repeat (TO + 2) tick();
    check("after_timeout_bit_count", int'(bit_count), 0);
  endtask

  task automatic do_relock();
    relock = 1'b1;
    tick();
    relock = 1'b0;
    if (m_state == M_UNLOCKED) m_state = M_IDLE;
    check("relock_unlocked", int'(unlocked), 0);
    check("relock_state", int'(state_dbg), 0);
    tick();
  endtask

  task automatic wait_lockout_end();
    int k;
    k = 0;
    while (locked_out && k < 3 * LO) begin
      tick();
      k++;
    end
    check("lockout_terminated", int'(locked_out), 0);
    m_state = M_IDLE;
    repeat (2) tick();
  endtask

  task automatic do_reset();
    exp_q.delete();
    reset = 1'b0;
    bit_valid = 1'b0;
    tick();
    check("rst_unlocked", int'(unlocked), 0);
    check("rst_locked_out", int'(locked_out), 0);
    check("rst_key_error", int'(key_error), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_bit_count", int'(bit_count), 0);
    check("rst_fail_count", int'(fail_count), 0);
    check("rst_state", int'(state_dbg), 0);
    reset   = 1'b1;
    m_state = M_IDLE;
    m_fail  = 0;
    tick();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int r;
    logic [3:0] w;
    tick();
    do_reset();

    // Correct key, then relock.
    send_attempt(KEY, 0);
    check("unlocked_held", int'(unlocked), 1);
    do_relock();

    // Single wrong key.
    do_reset();
    send_attempt(4'hF, 0);
    check("wrong_key_fail_count", int'(fail_count), 1);

    // Three wrong keys -> lockout; correct key during lockout is ignored.
    do_reset();
    send_attempt(4'hF, 0);
    send_attempt(4'h0, 0);
    send_attempt(4'h5, 0);
    send_attempt(KEY, 0);
    check("key_ignored_in_lockout", int'(state_dbg), 4);
    wait_lockout_end();
    send_attempt(KEY, 0);
    do_relock();

    // Abort after 2 bits, then a full correct key.
    partial(4'b0001, 2);
    send_attempt(KEY, 0);
    do_relock();

    // Slow correct key, and a bit landing exactly on the expiring idle counter.
    send_attempt(KEY, 3);
    do_relock();
    send_attempt(KEY, TO - 1);
    do_relock();

    // Reset mid-receive and mid-lockout.
    bit_valid = 1'b1; din = 1'b1; tick();
    din = 1'b0; tick();
    do_reset();
    send_attempt(4'h0, 0);
    send_attempt(4'h1, 1);
    send_attempt(4'h2, 0);
    repeat (5) tick();
    check("mid_lockout_state", int'(state_dbg), 4);
    do_reset();

    // Randomized attempts.
    for (int it = 0; it < 40; it++) begin
      if (m_state == M_UNLOCKED) do_relock();
      r = $urandom_range(0, 9);
      w = 4'($urandom_range(0, 15));
      if (r < 3) send_attempt(KEY, $urandom_range(0, TO - 1));
      else if (r < 8) send_attempt(w, $urandom_range(0, TO - 1));
      else partial(w, $urandom_range(1, N - 1));
      if (m_state == M_LOCKED) wait_lockout_end();
    end

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
